// File: rtl/bp_btb_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Looked up combinationally from the fetch PC and trained from resolved EX outcomes.
module bp_btb_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lookup_vld,
  input  logic [ADDR_W-1:0] i_pcF,
  output logic              o_hit,
  output logic              o_pred_taken,
  output logic [ADDR_W-1:0] o_pred_target,
  input  logic              i_upd_vld,
  input  logic [ADDR_W-1:0] i_upd_pc,
  input  logic              i_upd_uncond,
  input  logic              i_upd_taken,
  input  logic [ADDR_W-1:0] i_upd_target,
  input  logic              i_upd_mispred,
  input  logic              i_inval_all,
  output logic [PERF_W-1:0] o_hit_cnt,
  output logic [PERF_W-1:0] o_mispred_cnt
);

  localparam int INDEX_W = $clog2(ENTRIES);
  localparam int TAG_W   = ADDR_W - INDEX_W - 2;
  localparam logic [CNT_W-1:0]  CTR_MAX  = '1;
  // Weakly-taken: only the MSB set.
  localparam logic [CNT_W-1:0]  CTR_WEAK = CTR_MAX ^ (CTR_MAX >> 1);
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  function automatic logic [CNT_W-1:0] ctrInc(input logic [CNT_W-1:0] c);
    return (c == CTR_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] ctrDec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  function automatic logic [PERF_W-1:0] perfInc(input logic [PERF_W-1:0] c);
    return (c == PERF_MAX) ? c : c + PERF_W'(1);
  endfunction

  logic [ENTRIES-1:0] validMem;
  logic [TAG_W-1:0]   tagMem [ENTRIES];
  logic [ADDR_W-1:0]  tgtMem [ENTRIES];
  logic [CNT_W-1:0]   ctrMem [ENTRIES];
  logic [ENTRIES-1:0] uncMem;

  logic [INDEX_W-1:0] lkIdx;
  logic [TAG_W-1:0]   lkTag;
  logic [INDEX_W-1:0] updIdx;
  logic [TAG_W-1:0]   updTag;
  logic               updHit;
  logic               unusedPcLsbs;

  assign lkIdx  = i_pcF[INDEX_W+1:2];
  assign lkTag  = i_pcF[ADDR_W-1:INDEX_W+2];
  assign updIdx = i_upd_pc[INDEX_W+1:2];
  assign updTag = i_upd_pc[ADDR_W-1:INDEX_W+2];
  // Instructions are word aligned; the byte offset never selects an entry.
  assign unusedPcLsbs = ^{i_pcF[1:0], i_upd_pc[1:0]};

  // Lookup: zero latency, reads pre-update table contents (no bypass).
  assign o_hit         = validMem[lkIdx] && (tagMem[lkIdx] == lkTag);
  assign o_pred_taken  = o_hit && (uncMem[lkIdx] || ctrMem[lkIdx][CNT_W-1]);
  assign o_pred_target = o_hit ? tgtMem[lkIdx] : '0;

  assign updHit = validMem[updIdx] && (tagMem[updIdx] == updTag);

  logic              wrEn;
  logic [ADDR_W-1:0] wrTgt;
  logic [CNT_W-1:0]  wrCtr;
  logic              wrUnc;

  always_comb begin
    wrEn  = 1'b0;
    wrTgt = tgtMem[updIdx];
    wrCtr = ctrMem[updIdx];
    wrUnc = uncMem[updIdx];
    if (i_upd_vld && !i_inval_all) begin
      if (updHit) begin
        wrEn = 1'b1;
        if (i_upd_uncond) begin
          wrCtr = CTR_MAX;
          wrUnc = 1'b1;
          wrTgt = i_upd_target;
        end else begin
          wrUnc = 1'b0;
          if (i_upd_taken) begin
            wrCtr = ctrInc(ctrMem[updIdx]);
            wrTgt = i_upd_target;
          end else begin
            wrCtr = ctrDec(ctrMem[updIdx]);
          end
        end
      end else if (i_upd_taken || i_upd_uncond) begin
        // Allocate only for taken outcomes; not-taken misses leave the table alone.
        wrEn  = 1'b1;
        wrTgt = i_upd_target;
        wrCtr = i_upd_uncond ? CTR_MAX : CTR_WEAK;
        wrUnc = i_upd_uncond;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      validMem <= '0;
      uncMem   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tagMem[i] <= '0;
        tgtMem[i] <= '0;
        ctrMem[i] <= '0;
      end
    end else if (i_inval_all) begin
      validMem <= '0;
    end else if (wrEn) begin
      validMem[updIdx] <= 1'b1;
      tagMem[updIdx]   <= updTag;
      tgtMem[updIdx]   <= wrTgt;
      ctrMem[updIdx]   <= wrCtr;
      uncMem[updIdx]   <= wrUnc;
    end
  end

  // Perf counters survive invalidation and saturate instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hit_cnt     <= '0;
      o_mispred_cnt <= '0;
    end else begin
      if (i_lookup_vld && o_hit)
        o_hit_cnt <= perfInc(o_hit_cnt);
      if (i_upd_vld && i_upd_mispred)
        o_mispred_cnt <= perfInc(o_mispred_cnt);
    end
  end

endmodule

// File: doc/bp_btb_predictor.md
Name: bp_btb_predictor

Overview:
Parametrised direct-mapped branch target buffer with per-entry saturating direction counters for the 5-stage RV32I pipeline. It is looked up combinationally with the fetch PC and predicts next-PC in IF. It is trained from EX with resolved branch/jump outcomes, replacing the static predict-not-taken / flush-on-EX-branch scheme. It also keeps saturating hit and mispredict performance counters for debug readout.

Parameters:
ADDR_W, 32, PC/target width in bits
ENTRIES, 16, number of BTB entries; power of two, at least 2; INDEX_W = log2(ENTRIES)
CNT_W, 2, direction counter width in bits; at least 1
PERF_W, 32, performance counter width in bits

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_lookup_vld  in  1  fetch PC valid (IF not stalled, not flushed)
i_pcF  in  ADDR_W  fetch PC
o_hit  out  1  valid entry with matching tag at i_pcF
o_pred_taken  out  1  predicted taken (o_hit and counter MSB = 1)
o_pred_target  out  ADDR_W  stored target; drives next-PC when o_pred_taken
i_upd_vld  in  1  resolved control-flow instruction in EX
i_upd_pc  in  ADDR_W  PC of resolved instruction
i_upd_uncond  in  1  instruction is JAL/JALR (always taken)
i_upd_taken  in  1  resolved direction
i_upd_target  in  ADDR_W  resolved target address
i_upd_mispred  in  1  EX detected a mispredict (direction or target)
i_inval_all  in  1  synchronous invalidate of all entries (fence.i / debug)
o_hit_cnt  out  PERF_W  count of lookups that hit
o_mispred_cnt  out  PERF_W  count of mispredicts

Behaviour:
- Index = pc[INDEX_W+1:2]. Tag = pc[ADDR_W-1:INDEX_W+2]. pc[1:0] is ignored.
- Each entry holds: valid, tag, target[ADDR_W], ctr[CNT_W], uncond.
- Lookup is purely combinational from i_pcF and the table, with zero latency.
- o_hit = valid & (tag match).
- o_pred_taken = o_hit & (uncond | ctr[CNT_W-1]).
- o_pred_target = entry target when o_hit, else 0.
- Outputs do not depend on i_lookup_vld; that input only gates o_hit_cnt.
- Update is applied at the posedge when i_upd_vld=1.
- Update on tag hit, conditional branch: ctr increments if taken and decrements if not taken, saturating at 0 and 2^CNT_W-1. If taken, target is overwritten with i_upd_target. uncond is cleared.
- Update on tag hit, i_upd_uncond=1: ctr is set to max, uncond=1, target overwritten.
- Update on miss or invalid entry with i_upd_taken=1 (or uncond): allocate by overwriting the entry. Set valid=1 and tag. Set target=i_upd_target. Set ctr = max if uncond, else 2^(CNT_W-1) (weakly taken). Set uncond = i_upd_uncond.
- Update on miss with not-taken conditional: no allocation; the table is unchanged.
- Read/write same cycle: a lookup at the index being updated sees the pre-update contents; there is no bypass. The new value is visible from the next cycle.
- i_inval_all clears all valid bits at the posedge.
- i_inval_all has priority over a simultaneous update; that update is dropped, but its perf counting still occurs.
- o_hit_cnt increments when i_lookup_vld & o_hit.
- o_mispred_cnt increments when i_upd_vld & i_upd_mispred.
- Both perf counters saturate at 2^PERF_W-1 and never wrap. They are not cleared by i_inval_all.
- Reset (async, i_rst_n=0): all valid bits = 0, ctr/tag/target/uncond = 0, both perf counters = 0.
- During and after reset: o_hit=0, o_pred_taken=0, o_pred_target=0.
- Reset asserted mid-update discards that update. The first update after release writes normally.
- X-safety: no output is X after reset, regardless of i_pcF.

Test Plan:
- Reset then lookup pcF=0x0000_0040 -> o_hit=0, o_pred_taken=0, o_pred_target=0, o_hit_cnt=0.
- Update pc=0x0000_0040, taken=1, target=0x0000_0100, uncond=0. Next cycle lookup 0x40 -> hit=1, pred_taken=1 (ctr=2), target=0x100. Same-cycle lookup during the update -> hit=0.
- Train the 0x40 entry not-taken twice -> ctr 2->1->0, pred_taken=0, hit=1. Two more not-taken updates -> ctr stays 0. Three taken updates -> ctr saturates at 3.
- Alias: ENTRIES=16, update pc=0x0000_0440 (same index 0, different tag) taken, target 0x200 -> lookup 0x40 hit=0; lookup 0x440 hit=1, target=0x200. A not-taken miss at 0x840 -> no allocation, 0x440 is still a hit.
- JAL update pc=0x80, uncond=1, target=0x10, followed by a not-taken conditional update on that entry -> uncond cleared, ctr = max-1 = 2, pred_taken=1. Separately, i_inval_all asserted together with an update -> all lookups miss next cycle, update dropped.
- Perf counters: PERF_W=4, 20 hitting lookups -> o_hit_cnt=15 (saturated). 3 updates with mispred=1 -> o_mispred_cnt=3. Reset mid-count -> both 0.
